// File: rtl/vic_pkg.sv
// Shared constants and state encoding for the VIC register-port bus master.
package vic_pkg;
  localparam int CONFREG_WIDTH     = 4;
  localparam int CONFREGADDR_WIDTH = 5;
  localparam int ARRAY_LENGTH      = 32;
  localparam int ENA_INDEX         = 31;
  localparam int NIBBLES           = 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;
endpackage

// File: rtl/vic_reg_master.sv
// CPU bus to VIC configuration register file bridge: one 32-bit word becomes
// eight 4-bit register beats; one response is returned per accepted request.
module vic_reg_master
  import vic_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFA0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_bus_valid,
  output logic                         o_bus_ready,
  input  logic [31:0]                  i_bus_addr,
  input  logic                         i_bus_we,
  input  logic [31:0]                  i_bus_wdata,
  input  logic [3:0]                   i_bus_be,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [31:0]                  o_rsp_rdata,
  output logic                         o_rsp_err,
  output logic [CONFREGADDR_WIDTH-1:0] o_VIC_regaddr,
  output logic [CONFREG_WIDTH-1:0]     o_VIC_data,
  output logic                         o_VIC_we,
  input  logic [CONFREG_WIDTH-1:0]     i_VIC_data
);
  state_t state_q, state_d;
  logic [2:0]                   beat_q;
  logic [1:0]                   idx_q;
  logic [31:0]                  wdata_q;
  logic [3:0]                   be_q;
  logic                         err_q;
  logic [31:0]                  rdata_q;
  logic [CONFREGADDR_WIDTH-1:0] last_addr_q;
  logic [CONFREG_WIDTH-1:0]     last_data_q;

  logic                         hit, accept, last_beat;
  logic [CONFREGADDR_WIDTH-1:0] cur_addr;
  logic [CONFREG_WIDTH-1:0]     cur_nib;

  assign hit       = (i_bus_addr[31:4] == BASE_ADDR[31:4]) && (i_bus_addr[1:0] == 2'b00);
  // Gated by rst so the bus never sees ready while the block is held in reset.
  assign o_bus_ready = (state_q == IDLE) && rst;
  assign accept    = i_bus_valid && o_bus_ready;
  assign last_beat = (beat_q == 3'(NIBBLES - 1));
  assign cur_addr  = {idx_q, beat_q};
  assign cur_nib   = wdata_q[int'(beat_q) * CONFREG_WIDTH +: CONFREG_WIDTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = !hit ? RESP : (i_bus_we ? WRITE : READ);
      WRITE:   if (last_beat) state_d = RESP;
      READ:    if (last_beat) state_d = DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register-port outputs keep their last driven value outside the beat states.
  always_comb begin
    o_VIC_regaddr = last_addr_q;
    o_VIC_data    = last_data_q;
    o_VIC_we      = 1'b0;
    if (state_q == WRITE) begin
      o_VIC_regaddr = cur_addr;
      o_VIC_data    = cur_nib;
      o_VIC_we      = be_q[beat_q[2:1]];
    end else if (state_q == READ) begin
      o_VIC_regaddr = cur_addr;
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= i_bus_addr[3:2];
        wdata_q <= i_bus_wdata;
        be_q    <= i_bus_be;
        err_q   <= !hit;
        rdata_q <= '0;
        beat_q  <= '0;
      end
      if (state_q == WRITE || state_q == READ) begin
        beat_q      <= beat_q + 3'd1;
        last_addr_q <= cur_addr;
      end
      if (state_q == WRITE) last_data_q <= cur_nib;
      // Read data lags the address by one cycle, so beat k's edge returns nibble k-1.
      if ((state_q == READ && beat_q != 3'd0) || state_q == DRAIN)
        rdata_q <= {i_VIC_data, rdata_q[31:CONFREG_WIDTH]};
    end
  end
endmodule

// File: tb/tb_vic_reg_master.sv
// Directed bench for vic_reg_master with a behavioural 32x4 register file.
module tb_vic_reg_master;
  import vic_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FFA0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_bus_valid = 1'b0;
  logic        o_bus_ready;
  logic [31:0] i_bus_addr = '0;
  logic        i_bus_we = 1'b0;
  logic [31:0] i_bus_wdata = '0;
  logic [3:0]  i_bus_be = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [4:0]  o_VIC_regaddr;
  logic [3:0]  o_VIC_data;
  logic        o_VIC_we;
  logic [3:0]  i_VIC_data;

  int vectors = 0;
  int miscompares = 0;

  vic_reg_master #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .i_bus_valid(i_bus_valid), .o_bus_ready(o_bus_ready),
    .i_bus_addr(i_bus_addr), .i_bus_we(i_bus_we),
    .i_bus_wdata(i_bus_wdata), .i_bus_be(i_bus_be),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_VIC_regaddr(o_VIC_regaddr), .o_VIC_data(o_VIC_data),
    .o_VIC_we(o_VIC_we), .i_VIC_data(i_VIC_data)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, registered read; never reset by the master.
  logic [3:0] rf [ARRAY_LENGTH] = '{default: 4'h0};
  logic [3:0] rf_q = 4'h0;
  always @(posedge clk) begin
    if (o_VIC_we) rf[o_VIC_regaddr] <= o_VIC_data;
    rf_q <= rf[o_VIC_regaddr];
  end
  assign i_VIC_data = rf_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE (called just after a negedge) and checks each beat,
  // the response after `hold` cycles of backpressure, and the return to IDLE.
  task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                      input logic [3:0] be, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic hit;
    logic [31:0] rd_hold;
    hit = (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
    chk("ready_idle", o_bus_ready, 1);
    i_bus_valid = 1'b1; i_bus_addr = addr; i_bus_we = we; i_bus_wdata = wd; i_bus_be = be;
    @(negedge clk);
    i_bus_valid = 1'b0;
    if (hit) begin
      for (int k = 0; k < 8; k++) begin
        chk("beat_addr", o_VIC_regaddr, {27'd0, addr[3:2], 3'(k)});
        chk("beat_we", o_VIC_we, we ? be[k/2] : 1'b0);
        if (we) chk("beat_data", o_VIC_data, wd[4*k +: 4]);
        chk("beat_rsp_valid", o_rsp_valid, 0);
        chk("beat_ready", o_bus_ready, 0);
        @(negedge clk);
      end
      if (!we) begin
        chk("drain_addr", o_VIC_regaddr, {27'd0, addr[3:2], 3'd7});
        chk("drain_we", o_VIC_we, 0);
        chk("drain_rsp_valid", o_rsp_valid, 0);
        @(negedge clk);
      end
    end else begin
      chk("miss_we", o_VIC_we, 0);
    end
    chk("rsp_valid", o_rsp_valid, 1);
    chk("rsp_err", o_rsp_err, exp_err);
    chk("rsp_rdata", o_rsp_rdata, exp_rd);
    rd_hold = exp_rd;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_rdata", o_rsp_rdata, rd_hold);
      chk("hold_err", o_rsp_err, exp_err);
      chk("hold_ready", o_bus_ready, 0);
      chk("hold_we", o_VIC_we, 0);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk("post_rsp_valid", o_rsp_valid, 0);
    chk("post_ready", o_bus_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_ready", o_bus_ready, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    chk("rst_err", o_rsp_err, 0);
    chk("rst_regaddr", o_VIC_regaddr, 0);
    chk("rst_data", o_VIC_data, 0);
    chk("rst_we", o_VIC_we, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("first_ready", o_bus_ready, 1);

    // Full write of word 1 -> regs 8..15 = 1..8
    xact(BASE + 32'h4, 1'b1, 32'h8765_4321, 4'hF, 0, 32'h0, 1'b0);
    for (int r = 8; r < 16; r++) chk("rf_full_write", {28'd0, rf[r]}, r - 7);

    // Read back word 1
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 0, 32'h8765_4321, 1'b0);

    // Byte-enable mask on word 0, then read it back
    xact(BASE, 1'b1, 32'hFFFF_FFFF, 4'b0101, 0, 32'h0, 1'b0);
    xact(BASE, 1'b0, 32'h0, 4'hF, 0, 32'h00FF_00FF, 1'b0);

    // Address miss and misalignment
    xact(32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1);
    xact(BASE + 32'h2, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1);
    xact(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b1);
    chk("miss_no_write_r0", {28'd0, rf[2]}, 0);

    // Global enable via word 3 bit 28
    xact(BASE + 32'hC, 1'b1, 32'h1000_0000, 4'hF, 0, 32'h0, 1'b0);
    chk("global_enable", {28'd0, rf[ENA_INDEX]}, 1);
    chk("word3_low", {28'd0, rf[24]}, 0);

    // Backpressure: response held for 5 cycles
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 5, 32'h8765_4321, 1'b0);

    // Reset at write beat 3 of word 1
    i_bus_valid = 1'b1; i_bus_addr = BASE + 32'h4; i_bus_we = 1'b1;
    i_bus_wdata = 32'hAAAA_AAAA; i_bus_be = 4'hF;
    @(negedge clk);
    i_bus_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_beat3_addr", o_VIC_regaddr, 5'd11);
    chk("abort_beat3_we", o_VIC_we, 1);
    rst = 1'b0;
    #1;
    chk("abort_we", o_VIC_we, 0);
    chk("abort_ready", o_bus_ready, 0);
    chk("abort_rsp_valid", o_rsp_valid, 0);
    chk("abort_regaddr", o_VIC_regaddr, 0);
    @(negedge clk);
    chk("abort_hold_rsp_valid", o_rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", o_bus_ready, 1);
    chk("abort_release_rsp_valid", o_rsp_valid, 0);
    for (int r = 8; r < 11; r++) chk("abort_written", {28'd0, rf[r]}, 32'hA);
    for (int r = 11; r < 16; r++) chk("abort_untouched", {28'd0, rf[r]}, r - 7);

    // Normal operation resumes after the abandoned transaction
    xact(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 0, 32'h8765_4AAA, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
